// File: rtl/dt_pkg.sv
// Shared constants and types for the distance-transform result readout path.
package dt_pkg;

   localparam int ADDR_W = 14;
   localparam int DATA_W = 8;
   localparam int NPIX   = 16384;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      READ  = 2'd1,
      DRAIN = 2'd2,
      DONE  = 2'd3
   } rd_state_t;

   // One output FIFO entry: the pixel plus its end-of-frame marker.
   typedef struct packed {
      logic              last;
      logic [DATA_W-1:0] data;
   } pix_t;

endpackage

// File: rtl/res_fifo.sv
// Small synchronous FIFO holding pixels (with last flag) between res_RAM and the output link.
module res_fifo
   import dt_pkg::*;
#(
   parameter int DEPTH = 4,
   localparam int PW   = $clog2(DEPTH),
   localparam int CW   = PW + 1
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          push,
   input  pix_t          din,
   input  logic          pop,
   output pix_t          dout,
   output logic [CW-1:0] count
);

   pix_t          mem [DEPTH];
   logic [PW-1:0] wr_ptr;
   logic [PW-1:0] rd_ptr;

   // Caller guarantees no push when full and no pop when empty.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
         for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      end else begin
         if (push) begin
            mem[wr_ptr] <= din;
            wr_ptr      <= wr_ptr + 1'b1;
         end
         if (pop) rd_ptr <= rd_ptr + 1'b1;
         count <= count + CW'(push) - CW'(pop);
      end
   end

   assign dout = mem[rd_ptr];

endmodule

// File: rtl/res_readout.sv
// Streams one result frame out of res_RAM onto a valid/ready byte link with last flag and checksum.
module res_readout
   import dt_pkg::*;
#(
   parameter int DEPTH = 4
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   output logic              busy,
   output logic              done,
   output logic              res_rd,
   output logic [ADDR_W-1:0] res_addr,
   input  logic [DATA_W-1:0] res_di,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] out_data,
   output logic              out_last,
   output logic [15:0]       checksum
);

   localparam int CW = $clog2(DEPTH) + 1;
   localparam logic [ADDR_W:0] LAST_IDX = (ADDR_W + 1)'(NPIX - 1);

   rd_state_t         state, state_nxt;
   logic [ADDR_W:0]   issue_ptr;
   logic [ADDR_W:0]   recv_cnt;
   logic              inflight;
   logic [DATA_W-1:0] cap_data;
   logic              issue;
   logic              push;
   logic              pop;
   logic [CW-1:0]     fifo_cnt;
   pix_t              push_ent;
   pix_t              head;

   // A read is only issued if its pixel is guaranteed a FIFO slot.
   assign issue = (state == READ) && ((int'(fifo_cnt) + int'(inflight)) < DEPTH);
   assign push  = inflight;
   assign pop   = out_valid && out_ready;

   assign push_ent = '{last: (recv_cnt == LAST_IDX), data: cap_data};

   res_fifo #(.DEPTH(DEPTH)) u_fifo (
      .clk   (clk),
      .reset (reset),
      .push  (push),
      .din   (push_ent),
      .pop   (pop),
      .dout  (head),
      .count (fifo_cnt)
   );

   assign res_rd    = issue;
   assign res_addr  = issue_ptr[ADDR_W-1:0];
   assign out_valid = (fifo_cnt != '0);
   assign out_data  = head.data;
   assign out_last  = head.last;
   assign busy      = (state == READ) || (state == DRAIN);
   assign done      = (state == DONE);

   // DRAIN looks ahead at this cycle's pop so done follows the last pop by one cycle.
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (start) state_nxt = READ;
         READ:    if (issue && (issue_ptr == LAST_IDX)) state_nxt = DRAIN;
         DRAIN:   if (!inflight && ((fifo_cnt == '0) || ((fifo_cnt == CW'(1)) && pop)))
                     state_nxt = DONE;
         DONE:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // RAM data for a read issued this cycle is valid at the closing edge; hold it one cycle before the FIFO.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state     <= IDLE;
         issue_ptr <= '0;
         recv_cnt  <= '0;
         inflight  <= 1'b0;
         cap_data  <= '0;
         checksum  <= '0;
      end else begin
         state    <= state_nxt;
         inflight <= issue;
         if (issue) begin
            issue_ptr <= issue_ptr + 1'b1;
            cap_data  <= res_di;
         end
         if ((state == IDLE) && start) begin
            issue_ptr <= '0;
            recv_cnt  <= '0;
            checksum  <= '0;
         end else begin
            if (push) recv_cnt <= recv_cnt + 1'b1;
            if (pop)  checksum <= checksum + 16'(out_data);
         end
      end
   end

endmodule

// File: tb/tb_res_readout.sv
// Directed bench for res_readout: full frames with free-flowing, stalled and random ready, ignored starts, mid-frame reset.
module tb_res_readout;
   import dt_pkg::*;

   localparam int DEPTH = 4;
   localparam int N     = NPIX;

   logic              clk = 1'b0;
   logic              reset = 1'b0;
   logic              start = 1'b0;
   logic              busy, done, res_rd;
   logic [ADDR_W-1:0] res_addr;
   logic [DATA_W-1:0] res_di = '0;
   logic              out_valid;
   logic              out_ready = 1'b0;
   logic [DATA_W-1:0] out_data;
   logic              out_last;
   logic [15:0]       checksum;

   logic [7:0]  ram [N];
   int          checks = 0;
   int          errors = 0;
   int          k, issued, popped, done_cnt, last_cnt, last_pop_k, done_k, first_valid_k;
   logic [15:0] cs_model;
   logic        prev_stall, prev_last;
   logic [7:0]  prev_data;
   logic        sent300;

   res_readout #(.DEPTH(DEPTH)) dut (
      .clk       (clk),
      .reset     (reset),
      .start     (start),
      .busy      (busy),
      .done      (done),
      .res_rd    (res_rd),
      .res_addr  (res_addr),
      .res_di    (res_di),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data),
      .out_last  (out_last),
      .checksum  (checksum)
   );

   always #5 clk = ~clk;

   // RAM model: address sampled at negedge, data valid at the following posedge.
   always @(negedge clk) if (res_rd) res_di <= ram[res_addr];

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
      checks++;
      assert (got === want) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, got, want);
      end
   endtask

   task automatic clear_track();
      k = -1; issued = 0; popped = 0; done_cnt = 0; last_cnt = 0;
      last_pop_k = -1; done_k = -1; first_valid_k = -1;
      cs_model = '0; prev_stall = 1'b0; prev_last = 1'b0; prev_data = '0;
   endtask

   // One clock cycle: drive inputs and observe outputs at the negedge, ahead of the deciding posedge.
   task automatic cycle(input logic rdy, input logic st);
      @(negedge clk);
      out_ready = rdy;
      start     = st;
      k++;
      if (prev_stall) begin
         chk("hold_valid", 32'(out_valid), 32'd1);
         chk("hold_data", 32'(out_data), 32'(prev_data));
         chk("hold_last", 32'(out_last), 32'(prev_last));
      end
      chk("credit", 32'((issued - popped) <= DEPTH), 32'd1);
      if (res_rd) begin
         chk("addr", 32'(res_addr), 32'(issued[ADDR_W-1:0]));
         issued++;
      end
      if (out_valid && first_valid_k < 0) first_valid_k = k;
      if (out_valid && out_ready) begin
         chk("data", 32'(out_data), 32'(ram[popped]));
         chk("last", 32'(out_last), 32'(popped == N - 1));
         if (out_last) last_cnt++;
         cs_model   = cs_model + 16'(out_data);
         popped++;
         last_pop_k = k;
      end
      if (done) begin
         done_cnt++;
         done_k = k;
      end
      prev_stall = out_valid && !out_ready;
      prev_data  = out_data;
      prev_last  = out_last;
   endtask

   task automatic chk_all_zero(input string tag);
      chk({tag, "_busy"}, 32'(busy), 32'd0);
      chk({tag, "_done"}, 32'(done), 32'd0);
      chk({tag, "_rd"}, 32'(res_rd), 32'd0);
      chk({tag, "_addr"}, 32'(res_addr), 32'd0);
      chk({tag, "_valid"}, 32'(out_valid), 32'd0);
      chk({tag, "_data"}, 32'(out_data), 32'd0);
      chk({tag, "_last"}, 32'(out_last), 32'd0);
      chk({tag, "_cs"}, 32'(checksum), 32'd0);
   endtask

   initial begin
      for (int i = 0; i < N; i++) ram[i] = 8'(i);

      repeat (3) @(negedge clk);
      #1 chk_all_zero("rst");
      @(negedge clk) reset = 1'b1;

      // Frame A: ready always high, ramp data.
      clear_track();
      cycle(1'b1, 1'b1);
      chk("a_idle_busy", 32'(busy), 32'd0);
      cycle(1'b1, 1'b0);
      chk("a_busy_rise", 32'(busy), 32'd1);
      chk("a_rd_first", 32'(res_rd), 32'd1);
      while (done_cnt == 0 && k < N + 50) cycle(1'b1, 1'b0);
      repeat (5) cycle(1'b1, 1'b0);
      chk("a_popped", 32'(popped), 32'(N));
      chk("a_issued", 32'(issued), 32'(N));
      chk("a_last_cnt", 32'(last_cnt), 32'd1);
      chk("a_first_valid", 32'(first_valid_k), 32'd3);
      chk("a_last_pop_k", 32'(last_pop_k), 32'(N + 2));
      chk("a_done_k", 32'(done_k), 32'(N + 3));
      chk("a_done_cnt", 32'(done_cnt), 32'd1);
      chk("a_cs_model", 32'(checksum), 32'(cs_model));
      // 64 repeats of 0..255 sum to 0x1FE000.
      chk("a_cs_const", 32'(checksum), 32'h0000_E000);
      chk("a_busy_end", 32'(busy), 32'd0);

      // Frame B: 100 stalled cycles, then random ready; extra starts at pixel 300 and in DONE.
      clear_track();
      sent300 = 1'b0;
      cycle(1'b0, 1'b1);
      repeat (100) cycle(1'b0, 1'b0);
      chk("b_stall_reads", 32'(issued), 32'd4);
      chk("b_stall_rd", 32'(res_rd), 32'd0);
      chk("b_stall_valid", 32'(out_valid), 32'd1);
      chk("b_stall_data", 32'(out_data), 32'd0);
      chk("b_stall_cs", 32'(checksum), 32'd0);
      while (popped < N && k < 60000) begin
         logic st;
         st = (popped == 300) && !sent300;
         if (st) sent300 = 1'b1;
         cycle(1'($urandom_range(0, 1)), st);
      end
      cycle(1'b0, 1'b1);
      chk("b_done_now", 32'(done), 32'd1);
      repeat (20) cycle(1'b1, 1'b0);
      chk("b_popped", 32'(popped), 32'(N));
      chk("b_issued", 32'(issued), 32'(N));
      chk("b_last_cnt", 32'(last_cnt), 32'd1);
      chk("b_done_cnt", 32'(done_cnt), 32'd1);
      chk("b_done_k", 32'(done_k), 32'(last_pop_k + 1));
      chk("b_cs_model", 32'(checksum), 32'(cs_model));
      chk("b_cs_const", 32'(checksum), 32'h0000_E000);
      chk("b_busy_end", 32'(busy), 32'd0);

      // Frame C: reset mid-frame, then a full all-zero frame from address 0.
      clear_track();
      cycle(1'b1, 1'b1);
      while (popped < 5000 && k < 6000) cycle(1'b1, 1'b0);
      chk("c_reached_5000", 32'(popped), 32'd5000);
      #2 reset = 1'b0;
      #1 chk_all_zero("mid_rst");
      @(negedge clk) reset = 1'b1;
      for (int i = 0; i < N; i++) ram[i] = 8'h00;
      clear_track();
      cycle(1'b1, 1'b1);
      while (done_cnt == 0 && k < N + 50) cycle(1'b1, 1'b0);
      repeat (3) cycle(1'b1, 1'b0);
      chk("c_popped", 32'(popped), 32'(N));
      chk("c_issued", 32'(issued), 32'(N));
      chk("c_last_pop_k", 32'(last_pop_k), 32'(N + 2));
      chk("c_last_cnt", 32'(last_cnt), 32'd1);
      chk("c_done_cnt", 32'(done_cnt), 32'd1);
      chk("c_cs", 32'(checksum), 32'd0);
      chk("c_busy_end", 32'(busy), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
